card_select_ctrl: RTL

- Producer side of the match-game pair check: decodes PS/2 scan codes into cursor moves and card picks on the 4x4 board.
- Presents the two picked card indices (data1, data2) to the compare/score counter.
- Re-arms when the counter's datareset acknowledges an Enter evaluation.
- Sits between the keyboard receiver (NewKB/KB_DAT) and the compare/score counter.

---
 rtl/card_game_pkg.sv | 42 ++++
 rtl/ps2_make_filter.sv | 29 ++
 rtl/card_select_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/card_game_pkg.sv
// Shared definitions for the match-game card selector: scan codes, FSM states,
// board index helpers. Card index encoding is {col[1:0], row[1:0]}.
package card_game_pkg;

  localparam logic [7:0] KEY_UP    = 8'h1D;
  localparam logic [7:0] KEY_DOWN  = 8'h1B;
  localparam logic [7:0] KEY_LEFT  = 8'h1C;
  localparam logic [7:0] KEY_RIGHT = 8'h23;
  localparam logic [7:0] KEY_PICK  = 8'h29;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  // Distinct idle indices so the score counter never sees a false match.
  localparam logic [3:0] IDX_RESET1 = 4'h0;
  localparam logic [3:0] IDX_RESET2 = 4'h4;

  typedef enum logic [1:0] {
    PICK1 = 2'd0,
    PICK2 = 2'd1,
    READY = 2'd2,
    OVER  = 2'd3
  } sel_state_t;

  // {col,row} -> row*4+col
  function automatic logic [3:0] idx_to_card(input logic [3:0] idx);
    return {idx[1:0], idx[3:2]};
  endfunction

  function automatic logic [3:0] card_to_idx(input logic [3:0] card);
    return {card[1:0], card[3:2]};
  endfunction

  function automatic logic [1:0] step_axis(input logic [1:0] v, input logic up,
                                           input logic wrap);
    logic [1:0] r;
    if (up) r = (v == 2'd3 && !wrap) ? v : v + 2'd1;
    else    r = (v == 2'd0 && !wrap) ? v : v - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/ps2_make_filter.sv
// Strips PS/2 break sequences (F0 xx) and extended prefixes (E0), passing only
// make codes on to the card selector as a one-cycle strobe.
module ps2_make_filter
  import card_game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_new,
  input  logic [7:0] i_byte,
  output logic       o_key_valid,
  output logic [7:0] o_key_code
);

  logic r_brk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_brk <= 1'b0;
    end else if (i_new) begin
      if (r_brk)                    r_brk <= 1'b0;
      else if (i_byte == KEY_BREAK) r_brk <= 1'b1;
    end
  end

  // The byte after F0 is the released key; it is swallowed here.
  assign o_key_valid = i_new && !r_brk && (i_byte != KEY_BREAK) && (i_byte != KEY_EXT);
  assign o_key_code  = i_byte;

endmodule

// File: rtl/card_select_ctrl.sv
// Cursor/pick controller for the 4x4 match board; presents a card pair to the
// score counter. Optional pick timeout under `CARD_SELECT_TIMEOUT_EN.
module card_select_ctrl
  import card_game_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_500_000,
  parameter bit          WRAP           = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        NewKB,
  input  logic [7:0]  KB_DAT,
  input  logic [15:0] flipped,
  input  logic        datareset,
  input  logic        gameend,
  output logic [3:0]  data1,
  output logic [3:0]  data2,
  output logic [3:0]  cursor,
  output logic [1:0]  pick_cnt,
  output logic        pair_ready,
  output logic        reject
);

  logic       w_key_valid;
  logic [7:0] w_key_code;

  sel_state_t r_state, w_state_next;
  logic [3:0] r_data1, w_data1_next;
  logic [3:0] r_data2, w_data2_next;
  logic [3:0] r_cursor, w_cursor_next;
  logic [1:0] r_pick_cnt, w_pick_cnt_next;
  logic       r_reject, w_reject_next;
  logic       w_timeout;
  logic       w_cur_flipped;
  logic [1:0] w_col, w_row;

  ps2_make_filter u_filter (
    .clk         (clk),
    .reset       (reset),
    .i_new       (NewKB),
    .i_byte      (KB_DAT),
    .o_key_valid (w_key_valid),
    .o_key_code  (w_key_code)
  );

  assign w_col         = r_cursor[3:2];
  assign w_row         = r_cursor[1:0];
  assign w_cur_flipped = flipped[idx_to_card(r_cursor)];

`ifdef CARD_SELECT_TIMEOUT_EN
  logic [23:0] r_to_cnt;

  assign w_timeout = (r_state == PICK2) && !w_key_valid &&
                     (r_to_cnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                           r_to_cnt <= 24'd0;
    else if (r_state != PICK2 || w_key_valid || w_timeout) r_to_cnt <= 24'd0;
    else                                                 r_to_cnt <= r_to_cnt + 24'd1;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= PICK1;
      r_data1    <= IDX_RESET1;
      r_data2    <= IDX_RESET2;
      r_cursor   <= 4'h0;
      r_pick_cnt <= 2'd0;
      r_reject   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_data1    <= w_data1_next;
      r_data2    <= w_data2_next;
      r_cursor   <= w_cursor_next;
      r_pick_cnt <= w_pick_cnt_next;
      r_reject   <= w_reject_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_data1_next    = r_data1;
    w_data2_next    = r_data2;
    w_cursor_next   = r_cursor;
    w_pick_cnt_next = r_pick_cnt;
    w_reject_next   = 1'b0;

    // Priority: gameend, then datareset, then timeout, then keyboard.
    if (gameend) begin
      w_state_next = OVER;
    end else if (r_state == OVER) begin
      w_state_next = OVER;
    end else if (datareset) begin
      w_state_next    = PICK1;
      w_data1_next    = IDX_RESET1;
      w_data2_next    = IDX_RESET2;
      w_pick_cnt_next = 2'd0;
    end else if (w_timeout) begin
      w_state_next    = PICK1;
      w_data1_next    = IDX_RESET1;
      w_pick_cnt_next = 2'd0;
      w_reject_next   = 1'b1;
    end else if (w_key_valid) begin
      case (w_key_code)
        KEY_UP:    w_cursor_next = {w_col, step_axis(w_row, 1'b0, WRAP)};
        KEY_DOWN:  w_cursor_next = {w_col, step_axis(w_row, 1'b1, WRAP)};
        KEY_LEFT:  w_cursor_next = {step_axis(w_col, 1'b0, WRAP), w_row};
        KEY_RIGHT: w_cursor_next = {step_axis(w_col, 1'b1, WRAP), w_row};
        KEY_PICK: begin
          case (r_state)
            PICK1: begin
              if (w_cur_flipped) begin
                w_reject_next = 1'b1;
              end else begin
                w_data1_next    = r_cursor;
                w_pick_cnt_next = 2'd1;
                w_state_next    = PICK2;
              end
            end
            PICK2: begin
              if (w_cur_flipped || r_cursor == r_data1) begin
                w_reject_next = 1'b1;
              end else begin
                w_data2_next    = r_cursor;
                w_pick_cnt_next = 2'd2;
                w_state_next    = READY;
              end
            end
            READY:   w_reject_next = 1'b1;
            default: w_reject_next = 1'b0;
          endcase
        end
        KEY_ENTER: w_cursor_next = r_cursor;  // evaluated by the score counter
        default:   w_cursor_next = r_cursor;
      endcase
    end
  end

  assign data1      = r_data1;
  assign data2      = r_data2;
  assign cursor     = r_cursor;
  assign pick_cnt   = r_pick_cnt;
  assign pair_ready = (r_state == READY);
  assign reject     = r_reject;

endmodule
